// File: rtl/text_cursor_writer.sv
// Turns a UART byte stream into character-RAM writes and tracks the text cursor.
// One register stage from byte to RAM write; form-feed walks every cell and stalls rx_ready meanwhile.
module text_cursor_writer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 4,
    parameter int                    COLS       = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic                      overrun,
    output logic                      we,
    output logic [$clog2(ROWS)-1:0]   w_row,
    output logic [$clog2(COLS)-1:0]   w_col,
    output logic [DATA_WIDTH-1:0]     din,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      busy
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    localparam logic [DATA_WIDTH-1:0] CH_BS  = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] CH_LF  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_FF  = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0] CH_CR  = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_SP  = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_TIL = DATA_WIDTH'(8'h7E);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           row_d, w_row_d, row_inc;
    logic [CW-1:0]           col_d, w_col_d;
    logic [DATA_WIDTH-1:0]   din_d;
    logic                    we_d, busy_d, rx_ready_d, overrun_d;
    logic                    accept;

    assign accept  = rx_valid && rx_ready;
    assign row_inc = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_ONE;

    always_comb begin
        state_d = state_q;
        row_d   = cursor_row;
        col_d   = cursor_col;
        we_d    = 1'b0;
        w_row_d = w_row;
        w_col_d = w_col;
        din_d   = din;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_data >= CH_SP && rx_data <= CH_TIL) begin
                        we_d    = 1'b1;
                        w_row_d = cursor_row;
                        w_col_d = cursor_col;
                        din_d   = rx_data;
                        if (cursor_col == COL_LAST) begin
                            row_d = row_inc;
                            col_d = '0;
                        end else begin
                            col_d = cursor_col + COL_ONE;
                        end
                    end else if (rx_data == CH_CR) begin
                        col_d = '0;
                    end else if (rx_data == CH_LF) begin
                        row_d = row_inc;
                        col_d = '0;
                    end else if (rx_data == CH_BS) begin
                        // Backspace at the home position is a no-op rather than wrapping.
                        if (cursor_col != '0) begin
                            col_d = cursor_col - COL_ONE;
                        end else if (cursor_row != '0) begin
                            row_d = cursor_row - ROW_ONE;
                            col_d = COL_LAST;
                        end
                        if (cursor_col != '0 || cursor_row != '0) begin
                            we_d    = 1'b1;
                            w_row_d = row_d;
                            w_col_d = col_d;
                            din_d   = CH_SP;
                        end
                    end else if (rx_data == CH_FF) begin
                        state_d = CLEAR;
                        we_d    = 1'b1;
                        w_row_d = '0;
                        w_col_d = '0;
                        din_d   = CLEAR_CHAR;
                    end
                end
            end
            CLEAR: begin
                // w_row/w_col double as the clear walk counter.
                if (w_row == ROW_LAST && w_col == COL_LAST) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    we_d  = 1'b1;
                    din_d = CLEAR_CHAR;
                    if (w_col == COL_LAST) begin
                        w_row_d = w_row + ROW_ONE;
                        w_col_d = '0;
                    end else begin
                        w_col_d = w_col + COL_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == CLEAR);
        rx_ready_d = (state_d == IDLE);
        overrun_d  = rx_valid && !rx_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cursor_row <= '0;
            cursor_col <= '0;
            we         <= 1'b0;
            w_row      <= '0;
            w_col      <= '0;
            din        <= '0;
            busy       <= 1'b0;
            rx_ready   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_row <= row_d;
            cursor_col <= col_d;
            we         <= we_d;
            w_row      <= w_row_d;
            w_col      <= w_col_d;
            din        <= din_d;
            busy       <= busy_d;
            rx_ready   <= rx_ready_d;
            overrun    <= overrun_d;
        end
    end
endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer: printable/control bytes, wrap, backspace, clear, overrun, reset mid-clear.
module tb_text_cursor_writer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready, overrun, we, busy;
    logic [1:0] w_row, cursor_row;
    logic [4:0] w_col, cursor_col;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_cursor_writer dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .overrun(overrun), .we(we), .w_row(w_row), .w_col(w_col),
        .din(din), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic chk_wr(input string tag, input int r, input int c, input int d);
        chk({tag, ".we"}, we, 1);
        chk({tag, ".w_row"}, w_row, r);
        chk({tag, ".w_col"}, w_col, c);
        chk({tag, ".din"}, din, d);
    endtask

    task automatic chk_cur(input string tag, input int r, input int c);
        chk({tag, ".cur_row"}, cursor_row, r);
        chk({tag, ".cur_col"}, cursor_col, c);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.we", we, 0);
        chk("rst.w_row", w_row, 0);
        chk("rst.w_col", w_col, 0);
        chk("rst.din", din, 0);
        chk_cur("rst", 0, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.rx_ready", rx_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.rx_ready", rx_ready, 1);

        // Back-to-back printable bytes
        send(8'h48);
        chk_wr("H", 0, 0, 8'h48);
        chk_cur("H", 0, 1);
        send(8'h69);
        chk_wr("i", 0, 1, 8'h69);
        chk_cur("i", 0, 2);
        chk("i.rx_ready", rx_ready, 1);
        step(1'b0, 8'h00);
        chk("pulse.we", we, 0);

        // Line wrap across a full row, then last cell wrap to origin
        send(8'h0D);
        chk("cr.we", we, 0);
        chk_cur("cr", 0, 0);
        for (int i = 0; i < 32; i++) send(8'h41);
        chk_wr("A31", 0, 31, 8'h41);
        chk_cur("A31", 1, 0);
        send(8'h42);
        chk_wr("B", 1, 0, 8'h42);
        chk_cur("B", 1, 1);
        send(8'h0A);
        send(8'h0A);
        chk_cur("lf2", 3, 0);
        for (int i = 0; i < 31; i++) send(8'h61);
        chk_cur("to331", 3, 31);
        send(8'h41);
        chk_wr("Alast", 3, 31, 8'h41);
        chk_cur("Alast", 0, 0);

        // CR/LF from (2,5)
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        chk_cur("at25", 2, 5);
        send(8'h0D);
        chk("crlf.cr.we", we, 0);
        chk_cur("crlf.cr", 2, 0);
        send(8'h0A);
        chk("crlf.lf.we", we, 0);
        chk_cur("crlf.lf", 3, 0);
        send(8'h0A);
        chk("lfwrap.we", we, 0);
        chk_cur("lfwrap", 0, 0);
        send(8'h41);
        chk_wr("A00", 0, 0, 8'h41);
        chk_cur("A00", 0, 1);

        // Backspace across row boundary, at home, and within a row
        send(8'h0A);
        chk_cur("at10", 1, 0);
        send(8'h08);
        chk_wr("bs.row", 0, 31, 8'h20);
        chk_cur("bs.row", 0, 31);
        send(8'h0D);
        send(8'h08);
        chk("bs.home.we", we, 0);
        chk_cur("bs.home", 0, 0);
        send(8'h51);
        send(8'h08);
        chk_wr("bs.col", 0, 0, 8'h20);
        chk_cur("bs.col", 0, 0);
        send(8'h07);
        chk("ign.we", we, 0);
        chk_cur("ign", 0, 0);
        send(8'h7F);
        chk("del.we", we, 0);
        chk_cur("del", 0, 0);

        // Form-feed clear from (2,7) with an overrun mid-clear
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'h71);
        chk_cur("at27", 2, 7);
        send(8'h0C);
        chk("ff.busy", busy, 1);
        chk("ff.rx_ready", rx_ready, 0);
        for (int k = 0; k < 128; k++) begin
            chk_wr($sformatf("clr%0d", k), k / 32, k % 32, 0);
            chk($sformatf("clr%0d.busy", k), busy, 1);
            chk($sformatf("clr%0d.rx_ready", k), rx_ready, 0);
            chk_cur($sformatf("clr%0d", k), 2, 7);
            chk($sformatf("clr%0d.overrun", k), overrun, (k == 51) ? 1 : 0);
            step(k == 50, 8'h55);
        end
        chk("clrdone.we", we, 0);
        chk("clrdone.busy", busy, 0);
        chk("clrdone.rx_ready", rx_ready, 1);
        chk("clrdone.overrun", overrun, 0);
        chk_cur("clrdone", 0, 0);

        // Reset during clear at cell 40
        send(8'h78);
        send(8'h0C);
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00);
        chk_wr("cell40", 1, 8, 0);
        chk_cur("cell40", 0, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.we", we, 0);
        chk("abort.busy", busy, 0);
        chk("abort.rx_ready", rx_ready, 0);
        chk_cur("abort", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00);
            chk($sformatf("post%0d.we", i), we, 0);
            chk($sformatf("post%0d.busy", i), busy, 0);
        end
        chk("post.rx_ready", rx_ready, 1);
        send(8'h5A);
        chk_wr("Z", 0, 0, 8'h5A);
        chk_cur("Z", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
